// File: rtl/cpu_types_pkg.sv
// Shared datapath types for the pipeline: word/register widths, ALU opcodes,
// writeback source select, and the ALU evaluation helper used by the execute stage.
package cpu_types_pkg;

    localparam int WORD_W = 32;
    localparam int REG_W  = 5;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [REG_W-1:0]  regbits_t;

    typedef enum logic [3:0] {
        ALU_SLL  = 4'h0,
        ALU_SRL  = 4'h1,
        ALU_ADD  = 4'h2,
        ALU_SUB  = 4'h3,
        ALU_AND  = 4'h4,
        ALU_OR   = 4'h5,
        ALU_XOR  = 4'h6,
        ALU_NOR  = 4'h7,
        ALU_SLT  = 4'h8,
        ALU_SLTU = 4'h9
    } aluop_t;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_NPC = 2'd2,
        WB_IMM = 2'd3
    } write_t;

    // All results wrap at 32 bits; shifts use only the low five bits of b.
    function automatic word_t alu_eval(aluop_t op, word_t a, word_t b);
        word_t r;
        r = '0;
        case (op)
            ALU_SLL:  r = a << b[4:0];
            ALU_SRL:  r = a >> b[4:0];
            ALU_ADD:  r = a + b;
            ALU_SUB:  r = a - b;
            ALU_AND:  r = a & b;
            ALU_OR:   r = a | b;
            ALU_XOR:  r = a ^ b;
            ALU_NOR:  r = ~(a | b);
            ALU_SLT:  r = {31'd0, ($signed(a) < $signed(b))};
            ALU_SLTU: r = {31'd0, (a < b)};
            default:  r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/exec_mem_if.sv
// Exec/mem pipeline register bundle: driven by the execute stage, consumed by memory.
interface exec_mem_if;
    import cpu_types_pkg::*;

    word_t    out_alu_result;
    word_t    out_instr_npc;
    word_t    out_dmemstore;
    regbits_t out_wsel;
    write_t   out_wdat_source;
    logic     out_halt;
    logic     out_dmemREN;
    logic     out_dmemWEN;

    modport exec (
        output out_alu_result, out_instr_npc, out_dmemstore, out_wsel,
               out_wdat_source, out_halt, out_dmemREN, out_dmemWEN
    );

    modport mem (
        input out_alu_result, out_instr_npc, out_dmemstore, out_wsel,
              out_wdat_source, out_halt, out_dmemREN, out_dmemWEN
    );

endinterface

// File: rtl/exec_stage_mul_seq.sv
// Iterative shift-and-add multiplier (low 32 bits of the product), retiring
// BITS_PER_CYCLE multiplier bits per BUSY cycle under a three-state FSM.
module mul_seq
    import cpu_types_pkg::*;
#(
    parameter int BITS_PER_CYCLE = 2
) (
    input  logic       CLK,
    input  logic       nRST,
    input  logic       start,
    input  logic       abort,
    input  logic       ack,
    input  word_t      a,
    input  word_t      b,
    output logic       busy,
    output logic       done,
    output word_t      result,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int STEPS = WORD_W / BITS_PER_CYCLE;
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(STEPS - 1);

    state_t           state;
    word_t            mcand;
    word_t            mplier;
    word_t            acc;
    logic [CNT_W-1:0] cnt;
    word_t            pp;

    always_comb begin
        pp = mcand * {{(WORD_W-BITS_PER_CYCLE){1'b0}}, mplier[BITS_PER_CYCLE-1:0]};
    end

    // abort wins over every state so a flushed multiply never reaches DONE.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state  <= IDLE;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else if (abort) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand  <= a;
                        mplier <= b;
                        acc    <= '0;
                        cnt    <= CNT_INIT;
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    acc    <= acc + pp;
                    mcand  <= mcand << BITS_PER_CYCLE;
                    mplier <= mplier >> BITS_PER_CYCLE;
                    cnt    <= cnt - CNT_W'(1);
                    if (cnt == '0) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (ack) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy      = ((state == IDLE) && start) || (state == BUSY);
    assign done      = (state == DONE);
    assign result    = acc;
    assign state_dbg = state;

endmodule

// File: rtl/exec_stage.sv
// Execute stage: combinational ALU, iterative MUL via mul_seq, and the exec/mem
// pipeline register that feeds the memory stage.
module exec_stage
    import cpu_types_pkg::*;
#(
    parameter int BITS_PER_CYCLE = 2
) (
    input  logic       CLK,
    input  logic       nRST,
    input  logic       en,
    input  logic       flush,
    input  aluop_t     aluop,
    input  logic       mul,
    input  word_t      porta,
    input  word_t      portb,
    input  regbits_t   wsel,
    input  write_t     wdat_source,
    input  logic       halt,
    input  logic       dmemREN,
    input  logic       dmemWEN,
    input  word_t      instr_npc,
    input  word_t      dmemstore,
    output logic       mul_stall,
    output logic [1:0] mul_state,
    exec_mem_if.exec   em
);

    word_t alu_out;
    word_t mul_result;
    logic  mul_done;
    logic  ld;

    // Handshake: the register takes a new instruction only when the hazard unit
    // advances (en) and no multiply is holding the stage (mul_stall); otherwise hold.
    assign ld = en && !mul_stall;

    always_comb begin
        alu_out = alu_eval(aluop, porta, portb);
    end

    mul_seq #(
        .BITS_PER_CYCLE(BITS_PER_CYCLE)
    ) u_mul_seq (
        .CLK       (CLK),
        .nRST      (nRST),
        .start     (mul),
        .abort     (en && flush),
        .ack       (ld),
        .a         (porta),
        .b         (portb),
        .busy      (mul_stall),
        .done      (mul_done),
        .result    (mul_result),
        .state_dbg (mul_state)
    );

    always_ff @(posedge CLK) begin
        if (!nRST || (ld && flush)) begin
            em.out_alu_result  <= '0;
            em.out_instr_npc   <= '0;
            em.out_dmemstore   <= '0;
            em.out_wsel        <= '0;
            em.out_wdat_source <= write_t'(0);
            em.out_halt        <= 1'b0;
            em.out_dmemREN     <= 1'b0;
            em.out_dmemWEN     <= 1'b0;
        end else if (ld) begin
            em.out_alu_result  <= mul_done ? mul_result : alu_out;
            em.out_instr_npc   <= instr_npc;
            em.out_dmemstore   <= dmemstore;
            em.out_wsel        <= wsel;
            em.out_wdat_source <= wdat_source;
            em.out_halt        <= halt;
            em.out_dmemREN     <= dmemREN;
            em.out_dmemWEN     <= dmemWEN;
        end
    end

endmodule

// File: doc/exec_stage.md
Name: exec_stage

Overview:
- Execute stage of the 5-stage pipeline: sits between decode and memory.
- Computes ALU results combinationally and runs an iterative multiplier (MUL, low 32 bits) through a small FSM.
- Holds the exec/mem pipeline register whose outputs drive the memory stage (exec_mem_if fields).
- Raises mul_stall so the hazard unit freezes upstream stages while a multiply is in flight.

Parameters:
- BITS_PER_CYCLE, 2, multiplier bits retired per BUSY cycle; must divide 32 (1, 2, 4, 8 legal).

Ports:
- CLK  in  1  clock
- nRST  in  1  reset, synchronous, active-low
- en  in  1  pipeline advance from hazard unit
- flush  in  1  load bubble into exec/mem register (qualified by en)
- aluop  in  4  aluop_t operation select
- mul  in  1  instruction is MUL (overrides aluop)
- porta, portb  in  32  operands (already forwarded)
- wsel  in  5  destination register
- wdat_source  in  write_t  writeback source
- halt, dmemREN, dmemWEN  in  1 each  control
- instr_npc, dmemstore  in  32 each  PC+4, store data
- mul_stall  out  1  multiply in progress
- out_alu_result, out_instr_npc, out_dmemstore  out  32 each  registered to mem stage
- out_wsel  out  5;  out_wdat_source  out  write_t;  out_halt, out_dmemREN, out_dmemWEN  out  1 each

Behaviour:
- Reset (nRST low at posedge): all out_* = 0, out_wdat_source = write_t'(0), FSM = IDLE, counter = 0, accumulators = 0. Reset overrides en/flush.
- ALU (combinational):
  - ops: ADD, SUB, AND, OR, XOR, NOR, SLL, SRL (shamt = portb[4:0]), SLT (signed), SLTU.
  - All ops are 32-bit wrap-around; no overflow flag or trap.
- FSM states IDLE, BUSY, DONE:
  - IDLE & mul: capture multiplicand = porta, multiplier = portb, acc = 0, counter = 32/BITS_PER_CYCLE-1; go to BUSY.
  - BUSY: each cycle add (multiplicand x low BITS_PER_CYCLE multiplier bits) to acc, shift multiplicand left / multiplier right, decrement counter. At counter==0, go to DONE.
  - DONE: result = acc. Leave to IDLE when the register loads (en=1).
- mul_stall = (state==IDLE && mul) || state==BUSY. Combinational; low in DONE.
- Latency with default: 1 capture cycle + 16 BUSY cycles (stall high 17 cycles); DONE cycle loads on the 18th edge.
- Register load enable ld = en && !mul_stall.
  - ld && !flush: out_* <= inputs; out_alu_result <= (state==DONE) ? acc : alu_out.
  - ld && flush: bubble: out_wsel, out_dmemREN, out_dmemWEN, out_halt = 0; other outputs 0.
  - !ld: all out_* hold.
- en && flush in any state forces FSM to IDLE, aborting an in-flight multiply (result discarded).
- DONE with en=0 (downstream data_stall): hold DONE and acc indefinitely; mul_stall stays 0.
- A mul arriving while in DONE is the same held instruction. The next mul is only accepted from IDLE.
- Synchronous reset mid-BUSY: abort to IDLE on that edge; outputs cleared.

Decomposition:
- cpu_types_pkg holds word_t, aluop_t encodings, write_t, and regbits_t.
- A local enum for FSM state lives in the module.
- One sub-module, mul_seq, holds the FSM, counter, and datapath.
  - Ports: CLK, nRST, start, abort, ack, a, b, busy, done, result.
  - exec_stage keeps the ALU and the pipeline register.

Test Plan:
- ADD porta=5, portb=7, wsel=3, en=1 -> after 1 edge out_alu_result=12, out_wsel=3, mul_stall never high.
- SLT porta=0xFFFFFFFF, portb=1 -> 1; SLTU same operands -> 0; SLL porta=1, portb=31 -> 0x80000000.
- MUL 0x00010003 x 5, en=1 -> mul_stall high exactly 17 cycles, out_alu_result=0x0005000F on edge 18.
- MUL 0xFFFFFFFF x 0xFFFFFFFF, en held 0 for 3 cycles in DONE -> result held, mul_stall 0, out_alu_result=0x00000001 after en rises.
- en=1, flush=1 with dmemWEN=1, wsel=9, halt=1 -> out_dmemWEN=0, out_wsel=0, out_halt=0. flush with en=0 -> outputs unchanged.
- nRST low for one edge at BUSY cycle 5 -> all out_* 0, FSM IDLE. With mul=0 afterwards, mul_stall=0.
